// File: rtl/cmos_pixel_pack_if.sv
// rtl/cmos_pixel_pack_if.sv - pixel input stream and packed word output bundle
interface cmos_pixel_pack_if;
  logic [15:0]  din;
  logic         din_vld;
  logic         din_sop;
  logic         din_eop;
  logic [127:0] dout;
  logic         dout_vld;
  logic         dout_sop;
  logic         dout_eop;

  // Pixel source side: drives the pixel stream, observes packed words
  modport master (
    output din, din_vld, din_sop, din_eop,
    input  dout, dout_vld, dout_sop, dout_eop
  );

  // Packer side: consumes pixels, produces packed words
  modport slave (
    input  din, din_vld, din_sop, din_eop,
    output dout, dout_vld, dout_sop, dout_eop
  );
endinterface

// File: rtl/cmos_pixel_pack.sv
// rtl/cmos_pixel_pack.sv - RGB565 to 128-bit word packer with frame length checks
module cmos_pixel_pack #(
  parameter int FRAME_PIXELS = 921600,
  parameter int CNT_W        = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  cmos_pixel_pack_if.slave        bus,
  output logic                    len_err,
  output logic [15:0]             frame_cnt
);

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    WAIT_SOP  = 2'd1,
    PACK      = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] ONE_PIX   = CNT_W'(1);

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   pcnt_q, pcnt_d;
  logic               sop_arm_q, sop_arm_d;
  logic [127:0]       buf_q, buf_d;
  logic [127:0]       dout_q, dout_d;
  logic               dout_vld_q, dout_vld_d;
  logic               dout_sop_q, dout_sop_d;
  logic               dout_eop_q, dout_eop_d;
  logic               len_err_q, len_err_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic [127:0]       word_fill;
  logic [127:0]       first_word;
  logic [CNT_W-1:0]   pcnt_inc;
  state_t             end_state;
  logic               restart;

  // Next-state, slot packing, word emission and frame length checking
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pcnt_d      = pcnt_q;
    sop_arm_d   = sop_arm_q;
    buf_d       = buf_q;
    dout_d      = dout_q;
    dout_vld_d  = 1'b0;
    dout_sop_d  = 1'b0;
    dout_eop_d  = 1'b0;
    len_err_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;

    // Current word with the incoming pixel dropped into slot idx; slot 0 is the MSBs
    word_fill = buf_q;
    word_fill[(7 - int'(idx_q)) * 16 +: 16] = bus.din;
    first_word = {bus.din, 112'd0};
    pcnt_inc   = (&pcnt_q) ? pcnt_q : pcnt_q + ONE_PIX;
    end_state  = enable ? WAIT_SOP : WAIT_INIT;
    // A sop pixel starts a frame both when waiting for one and mid-frame
    restart    = bus.din_vld && bus.din_sop && (state_q == WAIT_SOP || state_q == PACK);

    if (state_q == WAIT_INIT) begin
      if (enable) state_d = WAIT_SOP;
    end else if (restart) begin
      // Mid-frame sop abandons the partial word and is itself a framing error
      len_err_d = (state_q == PACK);
      pcnt_d    = ONE_PIX;
      if (bus.din_eop) begin
        dout_d      = first_word;
        dout_vld_d  = 1'b1;
        dout_sop_d  = 1'b1;
        dout_eop_d  = 1'b1;
        len_err_d   = (state_q == PACK) || (ONE_PIX != FRAME_LEN);
        frame_cnt_d = frame_cnt_q + 16'd1;
        idx_d       = 3'd0;
        buf_d       = '0;
        sop_arm_d   = 1'b0;
        state_d     = end_state;
      end else begin
        buf_d     = first_word;
        idx_d     = 3'd1;
        sop_arm_d = 1'b1;
        state_d   = PACK;
      end
    end else if (state_q == PACK && bus.din_vld) begin
      pcnt_d = pcnt_inc;
      if (bus.din_eop) begin
        dout_d      = word_fill;
        dout_vld_d  = 1'b1;
        dout_sop_d  = sop_arm_q;
        dout_eop_d  = 1'b1;
        len_err_d   = (pcnt_inc != FRAME_LEN);
        frame_cnt_d = frame_cnt_q + 16'd1;
        idx_d       = 3'd0;
        buf_d       = '0;
        sop_arm_d   = 1'b0;
        state_d     = end_state;
      end else if (idx_q == 3'd7) begin
        dout_d     = word_fill;
        dout_vld_d = 1'b1;
        dout_sop_d = sop_arm_q;
        sop_arm_d  = 1'b0;
        idx_d      = 3'd0;
        buf_d      = '0;
      end else begin
        buf_d = word_fill;
        idx_d = idx_q + 3'd1;
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_INIT;
      idx_q       <= 3'd0;
      pcnt_q      <= '0;
      sop_arm_q   <= 1'b0;
      buf_q       <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      dout_sop_q  <= 1'b0;
      dout_eop_q  <= 1'b0;
      len_err_q   <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pcnt_q      <= pcnt_d;
      sop_arm_q   <= sop_arm_d;
      buf_q       <= buf_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      dout_sop_q  <= dout_sop_d;
      dout_eop_q  <= dout_eop_d;
      len_err_q   <= len_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = dout_vld_q;
  assign bus.dout_sop = dout_sop_q;
  assign bus.dout_eop = dout_eop_q;
  assign len_err      = len_err_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_cmos_pixel_pack.sv
// tb/tb_cmos_pixel_pack.sv - scoreboard bench for cmos_pixel_pack
module tb_cmos_pixel_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        len_err;
  logic [15:0] frame_cnt;

  cmos_pixel_pack_if bus();

  cmos_pixel_pack #(.FRAME_PIXELS(16), .CNT_W(20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .bus       (bus),
    .len_err   (len_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int drv_cyc = 0;
  int fc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         vld;
    logic [127:0] data;
    logic         sop;
    logic         eop;
    logic         lerr;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic push(input logic vld, input logic [127:0] d, input logic s,
                      input logic e, input logic l, input int c);
    exp_t x;
    x.vld = vld; x.data = d; x.sop = s; x.eop = e; x.lerr = l; x.cyc = c;
    sb.push_back(x);
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic pix(input logic [15:0] d, input logic s, input logic e);
    @(posedge clk); #1;
    bus.din     = d;
    bus.din_vld = 1'b1;
    bus.din_sop = s;
    bus.din_eop = e;
    drv_cyc     = cyc;
  endtask

  // Idle cycles keep sop/eop high so that unqualified markers are exercised
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.din     = 16'hFFFF;
      bus.din_vld = 1'b0;
      bus.din_sop = 1'b1;
      bus.din_eop = 1'b1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout"}, bus.dout, 128'd0);
    check({tag, "_vld"}, {127'd0, bus.dout_vld}, 128'd0);
    check({tag, "_sop"}, {127'd0, bus.dout_sop}, 128'd0);
    check({tag, "_eop"}, {127'd0, bus.dout_eop}, 128'd0);
    check({tag, "_lerr"}, {127'd0, len_err}, 128'd0);
    check({tag, "_fcnt"}, {112'd0, frame_cnt}, 128'd0);
  endtask

  // Output monitor: every word strobe or error pulse must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (bus.dout_vld === 1'b1 || len_err === 1'b1)) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_out got vld=%b lerr=%b exp none", bus.dout_vld, len_err);
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("out_cyc", cyc, mon_e.cyc);
        check("out_vld", {127'd0, bus.dout_vld}, {127'd0, mon_e.vld});
        if (mon_e.vld) begin
          check("out_data", bus.dout, mon_e.data);
          check("out_sop", {127'd0, bus.dout_sop}, {127'd0, mon_e.sop});
          check("out_eop", {127'd0, bus.dout_eop}, {127'd0, mon_e.eop});
        end
        check("out_lerr", {127'd0, len_err}, {127'd0, mon_e.lerr});
      end
    end
  end

  logic [127:0] w;
  int           c_beef;

  initial begin
    rst_n = 1'b0; enable = 1'b0;
    bus.din = 16'd0; bus.din_vld = 1'b0; bus.din_sop = 1'b0; bus.din_eop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    rst_n  = 1'b1;
    enable = 1'b1;
    idle(2);

    // Full 16-pixel frame
    for (int i = 0; i < 16; i++) begin
      pix(16'(i + 1), i == 0, i == 15);
      if (i == 7)  push(1'b1, 128'h0001_0002_0003_0004_0005_0006_0007_0008, 1'b1, 1'b0, 1'b0, drv_cyc + 1);
      if (i == 15) push(1'b1, 128'h0009_000A_000B_000C_000D_000E_000F_0010, 1'b0, 1'b1, 1'b0, drv_cyc + 1);
    end
    idle(2);
    fc = 1;
    check("fcnt_full", {112'd0, frame_cnt}, 128'(fc));

    // Short frame of 13 pixels
    for (int i = 0; i < 13; i++) begin
      pix(16'(16'hA001 + i), i == 0, i == 12);
      if (i == 7)  push(1'b1, 128'hA001_A002_A003_A004_A005_A006_A007_A008, 1'b1, 1'b0, 1'b0, drv_cyc + 1);
      if (i == 12) push(1'b1, 128'hA009_A00A_A00B_A00C_A00D_0000_0000_0000, 1'b0, 1'b1, 1'b1, drv_cyc + 1);
    end
    idle(2);
    fc = 2;
    check("fcnt_short", {112'd0, frame_cnt}, 128'(fc));

    // Enable dropped mid-frame: frame completes, then input is ignored
    w = '0;
    for (int i = 0; i < 16; i++) begin
      pix(16'(16'h3001 + i), i == 0, i == 15);
      w = {w[111:0], 16'(16'h3001 + i)};
      if (i == 3) enable = 1'b0;
      if (i == 7)  push(1'b1, w, 1'b1, 1'b0, 1'b0, drv_cyc + 1);
      if (i == 15) push(1'b1, w, 1'b0, 1'b1, 1'b0, drv_cyc + 1);
    end
    idle(2);
    fc = 3;
    check("fcnt_en_drop", {112'd0, frame_cnt}, 128'(fc));
    for (int i = 0; i < 16; i++) pix(16'(16'h4000 + i), i == 0, i == 15);
    idle(2);
    check("fcnt_disabled", {112'd0, frame_cnt}, 128'(fc));
    enable = 1'b1;
    idle(2);
    for (int i = 0; i < 6; i++) pix(16'(16'h5000 + i), 1'b0, i == 5);
    for (int i = 0; i < 16; i++) begin
      pix(16'(16'h6001 + i), i == 0, i == 15);
      w = {w[111:0], 16'(16'h6001 + i)};
      if (i == 7)  push(1'b1, w, 1'b1, 1'b0, 1'b0, drv_cyc + 1);
      if (i == 15) push(1'b1, w, 1'b0, 1'b1, 1'b0, drv_cyc + 1);
    end
    idle(2);
    fc = 4;
    check("fcnt_resync", {112'd0, frame_cnt}, 128'(fc));

    // Premature sop after 5 pixels
    for (int i = 0; i < 5; i++) pix(16'(16'hD000 + i), i == 0, 1'b0);
    pix(16'hBEEF, 1'b1, 1'b0);
    c_beef = drv_cyc;
    push(1'b0, 128'd0, 1'b0, 1'b0, 1'b1, c_beef + 1);
    for (int i = 0; i < 15; i++) begin
      pix(16'(16'hE001 + i), 1'b0, i == 14);
      if (i == 6)  push(1'b1, 128'hBEEF_E001_E002_E003_E004_E005_E006_E007, 1'b1, 1'b0, 1'b0, drv_cyc + 1);
      if (i == 14) push(1'b1, 128'hE008_E009_E00A_E00B_E00C_E00D_E00E_E00F, 1'b0, 1'b1, 1'b0, drv_cyc + 1);
    end
    idle(2);
    fc = 5;
    check("fcnt_premature", {112'd0, frame_cnt}, 128'(fc));

    // One-pixel frame
    pix(16'h1234, 1'b1, 1'b1);
    push(1'b1, {16'h1234, 112'd0}, 1'b1, 1'b1, 1'b1, drv_cyc + 1);
    idle(2);
    fc = 6;
    check("fcnt_single", {112'd0, frame_cnt}, 128'(fc));

    // Reset after the third pixel of a frame
    pix(16'h7001, 1'b1, 1'b0);
    pix(16'h7002, 1'b0, 1'b0);
    pix(16'h7003, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.din_vld = 1'b0;
    @(posedge clk); #1;
    check_zero("midrst");
    rst_n = 1'b1;
    idle(2);
    for (int i = 0; i < 16; i++) begin
      pix(16'(16'h8001 + i), i == 0, i == 15);
      if (i == 7)  push(1'b1, 128'h8001_8002_8003_8004_8005_8006_8007_8008, 1'b1, 1'b0, 1'b0, drv_cyc + 1);
      if (i == 15) push(1'b1, 128'h8009_800A_800B_800C_800D_800E_800F_8010, 1'b0, 1'b1, 1'b0, drv_cyc + 1);
    end
    idle(2);
    fc = 1;
    check("fcnt_after_rst", {112'd0, frame_cnt}, 128'(fc));

    idle(4);
    check("sb_empty", 128'(sb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
